// File: rtl/irrigation_pkg.sv
// rtl/irrigation_pkg.sv - shared state encoding and default timing for the valve sequencer
package irrigation_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WATERING = 2'b01,
    ST_SETTLE   = 2'b10,
    ST_LOCKOUT  = 2'b11
  } state_e;

  localparam int DEF_WATER_TIME  = 8;
  localparam int DEF_SETTLE_TIME = 4;
  localparam int DEF_CNT_W       = 8;
  localparam logic [7:0] CYCLES_MAX = 8'hFF;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-stage synchronizer for a raw asynchronous sensor input
module sync_2ff (
  input  logic CLK,
  input  logic RESET,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/irrigation_valve_sequencer.sv
// rtl/irrigation_valve_sequencer.sv - timed watering cycle driving J/K pulses into the valve flip-flop
module irrigation_valve_sequencer
  import irrigation_pkg::*;
#(
  parameter int WATER_TIME  = DEF_WATER_TIME,
  parameter int SETTLE_TIME = DEF_SETTLE_TIME,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SOIL_DRY,
  input  logic       TANK_LOW,
  output logic       VALVE_J,
  output logic       VALVE_K,
  output logic       ALARM,
  output logic       BUSY,
  output logic [1:0] STATE,
  output logic [7:0] CYCLES
);

  logic soil_s;
  logic tank_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       cycles_q, cycles_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             alarm_q, alarm_d;
  logic             busy_q, busy_d;

  sync_2ff u_sync_soil (.CLK(CLK), .RESET(RESET), .d_i(SOIL_DRY), .q_o(soil_s));
  sync_2ff u_sync_tank (.CLK(CLK), .RESET(RESET), .d_i(TANK_LOW), .q_o(tank_s));

  // Low tank outranks everything; an abort from WATERING still closes the valve.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cycles_d = cycles_q;
    j_d      = 1'b0;
    k_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tank_s) begin
          state_d = ST_LOCKOUT;
        end else if (soil_s) begin
          state_d = ST_WATERING;
          j_d     = 1'b1;
          timer_d = CNT_W'(WATER_TIME - 1);
        end
      end
      ST_WATERING: begin
        if (tank_s) begin
          state_d = ST_LOCKOUT;
          k_d     = 1'b1;
        end else if (timer_q == '0) begin
          state_d = ST_SETTLE;
          k_d     = 1'b1;
          timer_d = CNT_W'(SETTLE_TIME - 1);
          if (cycles_q != CYCLES_MAX) cycles_d = cycles_q + 8'd1;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (tank_s) begin
          state_d = ST_LOCKOUT;
        end else if (timer_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      ST_LOCKOUT: begin
        if (!tank_s) state_d = ST_IDLE;
      end
    endcase
    alarm_d = (state_d == ST_LOCKOUT);
    busy_d  = (state_d == ST_WATERING) || (state_d == ST_SETTLE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      cycles_q <= 8'd0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      alarm_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cycles_q <= cycles_d;
      j_q      <= j_d;
      k_q      <= k_d;
      alarm_q  <= alarm_d;
      busy_q   <= busy_d;
    end
  end

  assign VALVE_J = j_q;
  assign VALVE_K = k_q;
  assign ALARM   = alarm_q;
  assign BUSY    = busy_q;
  assign STATE   = state_q;
  assign CYCLES  = cycles_q;

endmodule

// File: tb/tb_irrigation_valve_sequencer.sv
// tb/tb_irrigation_valve_sequencer.sv - vector table, directed corners and random stimulus vs reference model
module tb_irrigation_valve_sequencer;

  logic CLK, RESET, SOIL_DRY, TANK_LOW;
  logic d0_j, d0_k, d0_alarm, d0_busy;
  logic [1:0] d0_state;
  logic [7:0] d0_cycles;
  logic d1_j, d1_k, d1_alarm, d1_busy;
  logic [1:0] d1_state;
  logic [7:0] d1_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  irrigation_valve_sequencer dut (
    .CLK(CLK), .RESET(RESET), .SOIL_DRY(SOIL_DRY), .TANK_LOW(TANK_LOW),
    .VALVE_J(d0_j), .VALVE_K(d0_k), .ALARM(d0_alarm), .BUSY(d0_busy),
    .STATE(d0_state), .CYCLES(d0_cycles)
  );

  irrigation_valve_sequencer #(.WATER_TIME(1), .SETTLE_TIME(1), .CNT_W(8)) dut_fast (
    .CLK(CLK), .RESET(RESET), .SOIL_DRY(SOIL_DRY), .TANK_LOW(TANK_LOW),
    .VALVE_J(d1_j), .VALVE_K(d1_k), .ALARM(d1_alarm), .BUSY(d1_busy),
    .STATE(d1_state), .CYCLES(d1_cycles)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // mode: 0 idle, 1 watering, 2 settle, 3 lockout; el counts cycles spent in the timed phase
  typedef struct {
    int mode;
    int el;
    int cyc;
    bit j;
    bit k;
    bit s1, s2, t1, t2;
  } model_t;

  typedef struct {
    logic       soil;
    logic       tank;
    int         n;
    logic [1:0] st;
    logic       j, k, al, busy;
    logic [7:0] cyc;
  } vec_t;

  model_t m0, m1;
  vec_t   vecs[22];

  function automatic model_t mreset();
    model_t r;
    r.mode = 0; r.el = 0; r.cyc = 0; r.j = 0; r.k = 0;
    r.s1 = 0; r.s2 = 0; r.t1 = 0; r.t2 = 0;
    return r;
  endfunction

  function automatic model_t mstep(model_t m, bit soil, bit tank, int wt, int st);
    model_t n = m;
    bit ss = m.s2;
    bit ts = m.t2;
    n.s2 = m.s1; n.s1 = soil; n.t2 = m.t1; n.t1 = tank;
    n.j = 0; n.k = 0;
    case (m.mode)
      0: if (ts) n.mode = 3;
         else if (ss) begin n.mode = 1; n.el = 1; n.j = 1; end
      1: if (ts) begin n.mode = 3; n.k = 1; end
         else if (m.el == wt) begin
           n.mode = 2; n.k = 1; n.el = 1;
           if (m.cyc < 255) n.cyc = m.cyc + 1;
         end else n.el = m.el + 1;
      2: if (ts) n.mode = 3;
         else if (m.el == st) n.mode = 0;
         else n.el = m.el + 1;
      default: if (!ts) n.mode = 0;
    endcase
    return n;
  endfunction

  function automatic logic [13:0] mexp(model_t m);
    logic [1:0] s = 2'(m.mode);
    return {s, m.j, m.k, (m.mode == 3), (m.mode == 1 || m.mode == 2), 8'(m.cyc)};
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    if (!RESET) begin
      m0 = mreset();
      m1 = mreset();
    end else begin
      m0 = mstep(m0, SOIL_DRY, TANK_LOW, 8, 4);
      m1 = mstep(m1, SOIL_DRY, TANK_LOW, 1, 1);
    end
    #1;
    check("d0_outputs", {d0_state, d0_j, d0_k, d0_alarm, d0_busy, d0_cycles}, mexp(m0));
    check("d1_outputs", {d1_state, d1_j, d1_k, d1_alarm, d1_busy, d1_cycles}, mexp(m1));
    check("jk_exclusive", int'(d0_j & d0_k) + int'(d1_j & d1_k), 0);
  endtask

  initial begin
    logic [13:0] exp_v;
    // soil,tank,edges | state,J,K,ALARM,BUSY,CYCLES
    vecs[0]  = '{1, 0, 2, 2'd0, 0, 0, 0, 0, 8'd0};
    vecs[1]  = '{1, 0, 1, 2'd1, 1, 0, 0, 1, 8'd0};
    vecs[2]  = '{1, 0, 7, 2'd1, 0, 0, 0, 1, 8'd0};
    vecs[3]  = '{1, 0, 1, 2'd2, 0, 1, 0, 1, 8'd1};
    vecs[4]  = '{1, 0, 3, 2'd2, 0, 0, 0, 1, 8'd1};
    vecs[5]  = '{1, 0, 1, 2'd0, 0, 0, 0, 0, 8'd1};
    vecs[6]  = '{1, 0, 1, 2'd1, 1, 0, 0, 1, 8'd1};
    vecs[7]  = '{1, 0, 8, 2'd2, 0, 1, 0, 1, 8'd2};
    vecs[8]  = '{1, 0, 5, 2'd1, 1, 0, 0, 1, 8'd2};
    vecs[9]  = '{1, 0, 4, 2'd1, 0, 0, 0, 1, 8'd2};
    vecs[10] = '{1, 1, 2, 2'd1, 0, 0, 0, 1, 8'd2};
    vecs[11] = '{1, 1, 1, 2'd3, 0, 1, 1, 0, 8'd2};
    vecs[12] = '{1, 0, 2, 2'd3, 0, 0, 1, 0, 8'd2};
    vecs[13] = '{1, 0, 1, 2'd0, 0, 0, 0, 0, 8'd2};
    vecs[14] = '{1, 0, 1, 2'd1, 1, 0, 0, 1, 8'd2};
    vecs[15] = '{1, 0, 8, 2'd2, 0, 1, 0, 1, 8'd3};
    vecs[16] = '{0, 0, 4, 2'd0, 0, 0, 0, 0, 8'd3};
    vecs[17] = '{0, 0, 3, 2'd0, 0, 0, 0, 0, 8'd3};
    vecs[18] = '{1, 1, 2, 2'd0, 0, 0, 0, 0, 8'd3};
    vecs[19] = '{1, 1, 1, 2'd3, 0, 0, 1, 0, 8'd3};
    vecs[20] = '{1, 1, 5, 2'd3, 0, 0, 1, 0, 8'd3};
    vecs[21] = '{0, 0, 3, 2'd0, 0, 0, 0, 0, 8'd3};

    RESET = 1'b0; SOIL_DRY = 1'b1; TANK_LOW = 1'b0;
    m0 = mreset(); m1 = mreset();
    repeat (3) tick();
    check("reset_state", {d0_state, d0_j, d0_k, d0_alarm, d0_busy, d0_cycles}, 0);
    RESET = 1'b1;

    for (int i = 0; i < 22; i++) begin
      SOIL_DRY = vecs[i].soil;
      TANK_LOW = vecs[i].tank;
      repeat (vecs[i].n) tick();
      exp_v = {vecs[i].st, vecs[i].j, vecs[i].k, vecs[i].al, vecs[i].busy, vecs[i].cyc};
      check($sformatf("vec%0d", i), {d0_state, d0_j, d0_k, d0_alarm, d0_busy, d0_cycles}, exp_v);
    end

    // Reset dropped mid-WATERING clears outputs without waiting for a clock edge.
    SOIL_DRY = 1'b1; TANK_LOW = 1'b0;
    repeat (5) tick();
    check("mid_water_state", d0_state, 1);
    #1 RESET = 1'b0;
    #1;
    check("async_rst_d0", {d0_state, d0_j, d0_k, d0_alarm, d0_busy, d0_cycles}, 0);
    check("async_rst_d1", {d1_state, d1_j, d1_k, d1_alarm, d1_busy, d1_cycles}, 0);
    m0 = mreset(); m1 = mreset();
    repeat (2) tick();
    RESET = 1'b1;
    repeat (2) tick();
    check("restart_no_j", d0_j, 0);
    tick();
    check("restart_j", {d0_j, d0_busy}, 2'b11);

    for (int i = 0; i < 70; i++) begin
      SOIL_DRY = 1'($urandom_range(0, 1));
      TANK_LOW = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 40)) tick();
    end

    SOIL_DRY = 1'b1; TANK_LOW = 1'b0;
    repeat (800) tick();
    check("cycles_saturate", d1_cycles, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
